// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter that sequences timed setup/open/hold writes and clears into a shared D-latch bank.
// Latency: grant 1 cycle after req; a write occupies SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles. Backpressure: requesters hold req until granted.
// Optional LATCH_ARB_ABORT_EN: dropping the granted req during SETUP abandons the write.
module latch_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*DW-1:0]  wdata,
    input  logic                clr,
    output logic [NREQ-1:0]     gnt,
    output logic                done,
    output logic                busy,
    output logic [DW-1:0]       lat_d,
    output logic                lat_en,
    output logic                lat_rst
);

    localparam int MAXC = (SETUP_CYC > OPEN_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW = $clog2(NREQ);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SETUP, S_OPEN, S_HOLD, S_DONE
    } state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [PW-1:0]            ptr;
    logic                     clr_pend;
    logic                     lat_rst_q;
    logic                     abort;
    logic                     win_vld;
    logic [PW-1:0]            win_idx;
    logic [PW-1:0]            cand;
    logic [NREQ-1:0][DW-1:0]  wdata_arr;

    assign wdata_arr = wdata;

    // Bank reset follows the block reset without waiting for a clock edge.
    assign lat_rst = rst & lat_rst_q;

`ifdef LATCH_ARB_ABORT_EN
    assign abort = (state == S_SETUP) && !req[ptr];
`else
    assign abort = 1'b0;
`endif

    // Scan from the farthest candidate back to ptr+1 so the nearest asserted request wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= PW'(NREQ - 1);
            clr_pend  <= 1'b0;
            gnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            lat_d     <= '0;
            lat_en    <= 1'b0;
            lat_rst_q <= 1'b1;
        end else begin
            done      <= 1'b0;
            lat_rst_q <= 1'b1;
            clr_pend  <= clr_pend | clr;
            case (state)
                S_IDLE: begin
                    if (clr || clr_pend) begin
                        state     <= S_CLR;
                        clr_pend  <= 1'b0;
                        busy      <= 1'b1;
                        lat_rst_q <= 1'b0;
                    end else if (win_vld) begin
                        state <= S_SETUP;
                        cnt   <= SETUP_LD;
                        gnt   <= NREQ'(1) << win_idx;
                        ptr   <= win_idx;
                        lat_d <= wdata_arr[win_idx];
                        busy  <= 1'b1;
                    end
                end
                S_CLR: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    clr_pend <= clr;
                end
                S_SETUP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= S_OPEN;
                        cnt    <= OPEN_LD;
                        lat_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_OPEN: begin
                    if (cnt == '0) begin
                        state  <= S_HOLD;
                        cnt    <= HOLD_LD;
                        lat_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        gnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: default instance u0 plus a SETUP=3/OPEN=1/HOLD=2 instance u1, both tracked by a phase-based model.
module tb_latch_bank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req0, req1;
    logic [31:0] wdata0, wdata1;
    logic        clr0, clr1;
    logic [3:0]  gnt0, gnt1;
    logic        done0, done1, busy0, busy1, laten0, laten1, latrst0, latrst1;
    logic [7:0]  latd0, latd1;

    always #5 clk = ~clk;

    latch_bank_arbiter u0 (
        .clk(clk), .rst(rst), .req(req0), .wdata(wdata0), .clr(clr0),
        .gnt(gnt0), .done(done0), .busy(busy0), .lat_d(latd0),
        .lat_en(laten0), .lat_rst(latrst0)
    );

    latch_bank_arbiter #(.SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) u1 (
        .clk(clk), .rst(rst), .req(req1), .wdata(wdata1), .clr(clr1),
        .gnt(gnt1), .done(done1), .busy(busy1), .lat_d(latd1),
        .lat_en(laten1), .lat_rst(latrst1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: mode 0 idle, 1 clearing, 2 writing; t counts cycles since the grant edge.
    int         ps [2] = '{1, 3};
    int         po [2] = '{2, 1};
    int         ph [2] = '{1, 2};
    int         m_mode [2];
    int         m_t    [2];
    int         m_ptr  [2];
    int         m_win  [2];
    bit         m_pend [2];
    logic [7:0] m_d    [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_t[i] = 0; m_ptr[i] = NREQ - 1;
            m_win[i] = 0; m_pend[i] = 1'b0; m_d[i] = 8'h00;
        end
    endtask

    task automatic model_edge(input int i, input logic [3:0] rq, input logic [31:0] wd, input logic c);
        bit          found;
        bit          ab;
        int          idx;
        logic [31:0] sh;
        case (m_mode[i])
            0: begin
                if (c || m_pend[i]) begin
                    m_mode[i] = 1;
                    m_pend[i] = 1'b0;
                end else if (rq != 4'b0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NREQ; k++) begin
                        idx = (m_ptr[i] + k) % NREQ;
                        if (!found && ((rq >> idx) & 4'b1) != 4'b0) begin
                            found = 1'b1;
                            m_win[i] = idx;
                        end
                    end
                    m_ptr[i]  = m_win[i];
                    sh        = wd >> (8 * m_win[i]);
                    m_d[i]    = sh[7:0];
                    m_mode[i] = 2;
                    m_t[i]    = 0;
                end
            end
            1: begin
                m_mode[i] = 0;
                m_pend[i] = c;
            end
            default: begin
                if (c) m_pend[i] = 1'b1;
`ifdef LATCH_ARB_ABORT_EN
                ab = (m_t[i] < ps[i]) && (((rq >> m_win[i]) & 4'b1) == 4'b0);
`else
                ab = 1'b0;
`endif
                if (ab) begin
                    m_mode[i] = 0;
                end else begin
                    m_t[i]++;
                    if (m_t[i] > ps[i] + po[i] + ph[i]) m_mode[i] = 0;
                end
            end
        endcase
    endtask

    // Packed as {gnt, done, busy, lat_d, lat_en, lat_rst}.
    function automatic logic [15:0] model_out(input int i);
        logic [3:0] g;
        logic en, dn, bz, rn;
        int   w;
        w  = ps[i] + po[i] + ph[i];
        g  = 4'b0;
        if (m_mode[i] == 2 && m_t[i] < w) g = 4'(1 << m_win[i]);
        dn = (m_mode[i] == 2) && (m_t[i] == w);
        en = (m_mode[i] == 2) && (m_t[i] >= ps[i]) && (m_t[i] < ps[i] + po[i]);
        bz = (m_mode[i] != 0);
        rn = (m_mode[i] != 1);
        return {g, dn, bz, m_d[i], en, rn};
    endfunction

    function automatic logic [15:0] dut_out(input int i);
        if (i == 0) return {gnt0, done0, busy0, latd0, laten0, latrst0};
        return {gnt1, done1, busy1, latd1, laten1, latrst1};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        model_edge(0, req0, wdata0, clr0);
        model_edge(1, req1, wdata1, clr1);
        cyc++;
        #1;
        chk({nm, "/u0"}, dut_out(0), model_out(0));
        chk({nm, "/u1"}, dut_out(1), model_out(1));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] wd;
        logic       clr;
        logic [3:0] gnt;
        logic       en;
        logic       dn;
        logic       bz;
        logic       rn;
        logic [7:0] d;
    } vec_t;

    vec_t       tbl [9];
    logic [3:0] prev_g;
    logic [3:0] rr_g   [8];
    int         rr_c   [8];
    int         rr_n, done_c, clr_c, g_c, n_done, n_en, en_rise, bad_d;
    bit         found;
    logic [3:0] g_after;
    logic [3:0] rr_exp [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //             req     wd     clr   gnt     en    dn    bz    rn    d
        tbl[0] = '{4'b0001, 8'hA5, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[1] = '{4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[2] = '{4'b0000, 8'h00, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[3] = '{4'b0000, 8'h00, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[4] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[5] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[7] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[8] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};

        rst = 1'b0;
        req0 = '0; req1 = '0; wdata0 = '0; wdata1 = '0; clr0 = 1'b0; clr1 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset/u0", dut_out(0), 16'h0000);
        chk("reset/u1", dut_out(1), 16'h0000);
        #3 rst = 1'b1;
        #1;
        chk("release/u0", dut_out(0), model_out(0));
        chk("release_latrst", {15'b0, latrst0}, 16'd1);

        // Single write then an idle clear.
        for (int i = 0; i < 9; i++) begin
            req0 = tbl[i].req; wdata0 = {24'h0, tbl[i].wd}; clr0 = tbl[i].clr;
            step("vec_model");
            chk("vec_table", dut_out(0),
                {tbl[i].gnt, tbl[i].dn, tbl[i].bz, tbl[i].d, tbl[i].en, tbl[i].rn});
        end

        // Round robin with 1011 held; ptr is 0 after the single write.
        req0 = 4'b1011; wdata0 = 32'h44332211; prev_g = '0; rr_n = 0;
        for (int i = 0; i < 30; i++) begin
            step("rr");
            if (gnt0 != 4'b0 && prev_g == 4'b0 && rr_n < 8) begin
                rr_g[rr_n] = gnt0; rr_c[rr_n] = cyc; rr_n++;
            end
            prev_g = gnt0;
        end
        chk("rr_count", 16'(rr_n >= 4), 16'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < rr_n) chk("rr_grant", {12'h0, rr_g[i]}, {12'h0, rr_exp[i]});
            if (i > 0 && i < rr_n) chk("rr_period", 16'(rr_c[i] - rr_c[i-1]), 16'd6);
        end
        req0 = '0;
        repeat (8) step("rr_drain");

        // Clear arriving during OPEN is deferred until after DONE, ahead of a pending request.
        req0 = 4'b0100; wdata0 = 32'h00770000; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step("co_wait");
            found = laten0;
        end
        chk("co_open_found", {15'b0, found}, 16'd1);
        clr0 = 1'b1; req0 = 4'b0001; wdata0 = 32'h000000E1;
        step("co_pulse");
        clr0 = 1'b0; done_c = -1; clr_c = -1; g_c = -1; g_after = '0;
        for (int i = 0; i < 15; i++) begin
            step("co_seq");
            if (done0 && done_c < 0) done_c = cyc;
            if (!latrst0 && clr_c < 0) clr_c = cyc;
            if (gnt0 != 4'b0 && done_c >= 0 && g_c < 0) begin g_c = cyc; g_after = gnt0; end
        end
        chk("co_clr_after_done", 16'(clr_c > done_c && done_c >= 0), 16'd1);
        chk("co_gnt_after_clr", 16'(g_c > clr_c && clr_c >= 0), 16'd1);
        chk("co_gnt_value", {12'h0, g_after}, 16'h0001);
        req0 = '0;
        repeat (8) step("co_drain");

        // Requester 2 drops its request during SETUP.
        req0 = 4'b0100; wdata0 = 32'h005A0000;
        step("ab_grant");
        chk("ab_grant_val", {12'h0, gnt0}, 16'h0004);
        req0 = '0;
        step("ab_drop");
        n_done = 0; n_en = 0;
        for (int i = 0; i < 8; i++) begin
            step("ab_run");
            n_done += int'(done0);
            n_en   += int'(laten0);
        end
`ifdef LATCH_ARB_ABORT_EN
        chk("ab_gnt_after", {12'h0, gnt0}, 16'h0000);
        chk("ab_done_count", 16'(n_done), 16'd0);
        chk("ab_en_count", 16'(n_en), 16'd0);
`else
        chk("ab_done_count", 16'(n_done), 16'd1);
        chk("ab_en_count", 16'(n_en), 16'd1);
`endif

        // Async reset during OPEN, with a clear queued that must be dropped.
        req0 = 4'b0001; wdata0 = 32'h000000C7;
        step("ar_grant");
        clr0 = 1'b1;
        step("ar_open");
        clr0 = 1'b0;
        chk("ar_in_open", {15'b0, laten0}, 16'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_immediate/u0", dut_out(0), 16'h0000);
        chk("ar_immediate/u1", dut_out(1), 16'h0000);
        model_reset();
        req0 = 4'b1011; wdata0 = 32'h44332211;
        @(posedge clk); #1;
        chk("ar_held/u0", dut_out(0), 16'h0000);
        #3 rst = 1'b1;
        step("ar_first");
        chk("ar_first_gnt", {12'h0, gnt0}, 16'h0001);
        chk("ar_no_clear", {15'b0, latrst0}, 16'd1);
        req0 = '0;
        repeat (8) step("ar_drain");

        // Long-phase instance: one write from requester 2 with noisy wdata afterwards.
        req1 = 4'b0100; wdata1 = 32'h00C30000;
        step("sw_grant");
        chk("sw_gnt", {12'h0, gnt1}, 16'h0004);
        g_c = cyc; en_rise = -1; n_en = 0; done_c = -1; bad_d = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) req1 = '0;
            wdata1 = $urandom;
            step("sw_run");
            if (laten1 && en_rise < 0) en_rise = cyc - g_c;
            n_en += int'(laten1);
            if (done1 && done_c < 0) done_c = cyc - g_c;
            if (latd1 != 8'hC3) bad_d++;
        end
        chk("sw_en_rise", 16'(en_rise), 16'd3);
        chk("sw_en_count", 16'(n_en), 16'd1);
        chk("sw_done_off", 16'(done_c), 16'd6);
        chk("sw_d_stable", 16'(bad_d), 16'd0);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req1 = 4'($urandom_range(0, 15));
            wdata0 = $urandom; wdata1 = $urandom;
            clr0 = ($urandom_range(0, 19) == 0);
            clr1 = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
